sat_share_arbiter: RTL

Shares one 32-to-16-bit signed saturation datapath between NUM_REQ requesters, such as per-lane accumulator drains of the MAC array.
- Round-robin grant, with one requester accepted per cycle.
- The saturated result is registered and returned with the requester ID and a clip flag.
- A running clip counter is kept for the debug/status readout.

---
 rtl/sat_pkg.sv | 14 +
 rtl/sat32_to_16.sv | 19 +
 rtl/sat_share_arbiter.sv | 100 ++++++++++
 3 files changed

// File: rtl/sat_pkg.sv
// Shared constants, types and clip detection for the 32-to-16-bit signed saturation path.
package sat_pkg;

  localparam int SAT16_MAX = 32767;
  localparam int SAT16_MIN = -32768;

  typedef logic signed [31:0] acc32_t;
  typedef logic signed [15:0] q16_t;

  function automatic logic is_clipped(acc32_t v);
    return (v > acc32_t'(SAT16_MAX)) || (v < acc32_t'(SAT16_MIN));
  endfunction

endpackage

// File: rtl/sat32_to_16.sv
// Combinational signed saturation of a 32-bit value to the 16-bit range.
module sat32_to_16
  import sat_pkg::*;
(
  input  acc32_t din,
  output q16_t   dout
);

  always_comb begin
    if (din > acc32_t'(SAT16_MAX)) begin
      dout = q16_t'(SAT16_MAX);
    end else if (din < acc32_t'(SAT16_MIN)) begin
      dout = q16_t'(SAT16_MIN);
    end else begin
      dout = din[15:0];
    end
  end

endmodule

// File: rtl/sat_share_arbiter.sv
// Round-robin sharing of one saturation datapath between NUM_REQ requesters,
// with a registered result stage and a saturating count of clipped transfers.
module sat_share_arbiter
  import sat_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 4,
  parameter  int unsigned CNT_W   = 16,
  localparam int unsigned ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*32-1:0]   req_data,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [15:0]      out_data,
  output logic [ID_W-1:0]         out_id,
  output logic                    out_sat,
  input  logic                    clr_count,
  output logic [CNT_W-1:0]        sat_count
);

  logic              out_valid_q;
  q16_t              out_data_q;
  logic [ID_W-1:0]   out_id_q;
  logic              out_sat_q;
  logic [CNT_W-1:0]  sat_count_q;
  logic [ID_W-1:0]   rr_ptr_q;

  logic              can_load;
  logic              grant_found;
  logic              accept;
  logic [ID_W-1:0]   grant_idx;
  acc32_t            grant_data;
  q16_t              sat_data;
  logic              clip;

  // Scan from rr_ptr upward with modulo wrap; first valid requester wins.
  always_comb begin
    int unsigned idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    grant_data  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(rr_ptr_q) + k) % NUM_REQ;
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(idx);
        grant_data  = req_data[idx*32 +: 32];
      end
    end
  end

  assign can_load  = !out_valid_q || out_ready;
  assign accept    = rst_n && grant_found && can_load;
  assign req_ready = accept ? (NUM_REQ'(1) << grant_idx) : '0;

  sat32_to_16 u_sat (
    .din  (grant_data),
    .dout (sat_data)
  );

  assign clip = is_clipped(grant_data);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
      out_sat_q   <= 1'b0;
      sat_count_q <= '0;
      rr_ptr_q    <= '0;
    end else begin
      if (accept) begin
        out_valid_q <= 1'b1;
        out_data_q  <= sat_data;
        out_id_q    <= grant_idx;
        out_sat_q   <= clip;
        rr_ptr_q    <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end

      if (clr_count) begin
        sat_count_q <= '0;
      end else if (out_valid_q && out_ready && out_sat_q && (sat_count_q != '1)) begin
        sat_count_q <= sat_count_q + CNT_W'(1);
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;
  assign out_sat   = out_sat_q;
  assign sat_count = sat_count_q;

endmodule
